// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bounded loop so synthesis can unroll it for any 32-bit value.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  function automatic int cnt_width(input int width);
    return (clog2(width) < 1) ? 1 : clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// 1-bit combinational full subtractor: d = a - b - bin, bo = borrow out.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one fs_cell plus a registered borrow.
// Optional signed-overflow output ovf when SERIAL_SUB_OVF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one operand bit processed per clock
// DONE  | result valid, done pulses; start here re-launches directly
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_next;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic             d, bo;
  logic             last, accept;

  fs_cell u_cell (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (brw),
    .d   (d),
    .bo  (bo)
  );

  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign accept = start && ((state == IDLE) || (state == DONE));
  // Concatenate then slice so WIDTH == 1 needs no empty part-select.
  assign res_cat  = {d, res_sr};
  assign res_next = res_cat[WIDTH:1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last)  state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
      if (accept) begin
        a_sr <= a;
        b_sr <= b;
        brw  <= bin;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= res_next;
        brw    <= bo;
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          diff <= res_next;
          bout <= bo;
          zero <= (res_next == '0);
`ifdef SERIAL_SUB_OVF_EN
          // brw is the borrow into the MSB on this final step.
          ovf  <= brw ^ bo;
`endif
        end
      end
    end
  end

endmodule
